// File: rtl/sound_player.sv
// Playback stage for the sound recorder. It fetches 10-bit samples through the recorder's
// read_pointer/read_data port, one sample every SAMPLE_INTERVAL_CLK clocks, and drives a
// glitch-free PWM speaker output with a 1024-clock period.
//
// Ports:
//   clk, reset_clk     system clock; synchronous active-high reset
//   play_n             asynchronous active-low play button (2-FF synchronised, falling-edge start)
//   record_n           recorder's record request, active-low; low blocks or aborts playback
//   write_pointer      number of valid samples in the recorder memory (clip length)
//   read_pointer       sample address presented to the recorder
//   read_data          sample returned by the recorder, READ_LATENCY clocks after an address change
//   sample_out         current offset-binary sample (512 = silence)
//   pwm_out            registered PWM output, duty = level/1024
//   playing            high whenever the playback FSM is not IDLE
//   done               one-clock pulse at the end of the clip
//
// Optional feature: define SOUND_LOOP_EN for continuous looping; a second play press then stops playback.
// Without it, playback is single-shot and presses while playing are ignored.

module sound_player #(
  parameter int SAMPLE_INTERVAL_CLK = 6000,
  parameter int READ_LATENCY        = 2,
  parameter bit TWOS_COMPLEMENT     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_clk,
  input  logic        play_n,
  input  logic        record_n,
  input  logic [14:0] write_pointer,
  output logic [14:0] read_pointer,
  input  logic [9:0]  read_data,
  output logic [9:0]  sample_out,
  output logic        pwm_out,
  output logic        playing,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [12:0] INT_LAST   = 13'(SAMPLE_INTERVAL_CLK - 1);
  // FETCH occupies interval counts 0..READ_LATENCY-1, so LATCH always lands on count READ_LATENCY.
  localparam logic [12:0] FETCH_LAST = 13'(READ_LATENCY - 1);
  localparam logic [9:0]  SILENCE    = 10'd512;

  state_t      state_q, state_d;
  logic [12:0] int_cnt_q, int_cnt_d;
  logic [14:0] rd_ptr_q, rd_ptr_d;
  logic [9:0]  sample_q, sample_d;
  logic        done_q, done_d;

  logic        play_s1_q, play_s1_d;
  logic        play_s2_q, play_s2_d;
  logic        play_prev_q, play_prev_d;

  logic [9:0]  pwm_cnt_q, pwm_cnt_d;
  logic [9:0]  pwm_level_q, pwm_level_d;
  logic        pwm_out_q, pwm_out_d;

  logic        start_pulse;
  logic        stop_req;
  logic [15:0] rd_ptr_inc;
  logic        more_samples;
  logic [9:0]  latched_sample;

  // Falling edge of the synchronised button: previous sample high, current sample low.
  assign start_pulse  = play_prev_q & ~play_s2_q;

  // Widened so that pointer 32767 + 1 cannot wrap back below write_pointer.
  assign rd_ptr_inc   = {1'b0, rd_ptr_q} + 16'd1;
  assign more_samples = (rd_ptr_inc < {1'b0, write_pointer});

  // Two's-complement storage maps to offset binary by flipping the sign bit.
  assign latched_sample = TWOS_COMPLEMENT ? {~read_data[9], read_data[8:0]} : read_data;

  always_comb begin
    play_s1_d   = play_n;
    play_s2_d   = play_s1_q;
    play_prev_d = play_s2_q;
  end

  always_comb begin
    state_d   = state_q;
    int_cnt_d = int_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    sample_d  = sample_q;
    done_d    = 1'b0;
    stop_req  = 1'b0;

    // The interval counter only runs during playback and wraps every sample period.
    if (state_q != IDLE) begin
      int_cnt_d = (int_cnt_q == INT_LAST) ? 13'd0 : int_cnt_q + 13'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_pulse && record_n && (write_pointer != 15'd0)) begin
          state_d   = FETCH;
          rd_ptr_d  = 15'd0;
          int_cnt_d = 13'd0;
        end
      end
      FETCH: begin
        if (int_cnt_q == FETCH_LAST) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        sample_d = latched_sample;
        state_d  = HOLD;
      end
      HOLD: begin
        if (int_cnt_q == INT_LAST) begin
          if (more_samples) begin
            rd_ptr_d = rd_ptr_inc[14:0];
            state_d  = FETCH;
          end else begin
            done_d   = 1'b1;
            rd_ptr_d = 15'd0;
`ifdef SOUND_LOOP_EN
            // Loop back to the first sample; the current sample stays on the speaker meanwhile.
            state_d  = FETCH;
`else
            state_d  = IDLE;
            sample_d = SILENCE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort (and, when looping, a second press) beats everything else, including end of clip.
    if (state_q != IDLE) begin
      stop_req = ~record_n;
`ifdef SOUND_LOOP_EN
      stop_req = stop_req | start_pulse;
`endif
      if (stop_req) begin
        state_d   = IDLE;
        rd_ptr_d  = 15'd0;
        sample_d  = SILENCE;
        int_cnt_d = 13'd0;
        done_d    = 1'b0;
      end
    end
  end

  // PWM level only changes at the period boundary so a pulse is never cut short or stretched.
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 10'd1;
    pwm_level_d = (pwm_cnt_q == 10'd1023) ? sample_q : pwm_level_q;
    pwm_out_d   = (pwm_cnt_q < pwm_level_q);
  end

  always_ff @(posedge clk) begin
    if (reset_clk) begin
      state_q     <= IDLE;
      int_cnt_q   <= 13'd0;
      rd_ptr_q    <= 15'd0;
      sample_q    <= SILENCE;
      done_q      <= 1'b0;
      // Synchroniser idles high so reset release cannot fake a button press.
      play_s1_q   <= 1'b1;
      play_s2_q   <= 1'b1;
      play_prev_q <= 1'b1;
      pwm_cnt_q   <= 10'd0;
      pwm_level_q <= SILENCE;
      pwm_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_cnt_q   <= int_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      sample_q    <= sample_d;
      done_q      <= done_d;
      play_s1_q   <= play_s1_d;
      play_s2_q   <= play_s2_d;
      play_prev_q <= play_prev_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_level_q <= pwm_level_d;
      pwm_out_q   <= pwm_out_d;
    end
  end

  assign read_pointer = rd_ptr_q;
  assign sample_out   = sample_q;
  assign pwm_out      = pwm_out_q;
  assign playing      = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_sound_player.sv
module tb_sound_player;

  localparam int SI = 2200;
  localparam int RL = 2;
`ifdef SOUND_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_clk;
  logic        play_n;
  logic        record_n;
  logic [14:0] write_pointer;
  logic [14:0] read_pointer;
  wire  [9:0]  read_data;
  logic [9:0]  sample_out;
  logic        pwm_out;
  logic        playing;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  sound_player #(
    .SAMPLE_INTERVAL_CLK(SI),
    .READ_LATENCY(RL),
    .TWOS_COMPLEMENT(1'b1)
  ) dut (
    .clk(clk),
    .reset_clk(reset_clk),
    .play_n(play_n),
    .record_n(record_n),
    .write_pointer(write_pointer),
    .read_pointer(read_pointer),
    .read_data(read_data),
    .sample_out(sample_out),
    .pwm_out(pwm_out),
    .playing(playing),
    .done(done)
  );

  // Recorder memory with a two-clock address-to-data latency; out-of-range reads float.
  logic [9:0]  mem [0:7];
  logic [14:0] rp_p1, rp_p2;
  always @(posedge clk) begin
    rp_p1 <= read_pointer;
    rp_p2 <= rp_p1;
  end
  assign read_data = (rp_p2 < write_pointer) ? mem[rp_p2[2:0]] : 10'bz;

  // Reference model: playback described as time elapsed since the start edge.
  int m_c = 0, m_t0 = 0, m_pc = 0, m_level = 512, m_sample = 512, m_rp = 0;
  bit m_active = 1'b0, m_pwm = 1'b0, m_done = 1'b0;
  bit h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;

  always @(posedge clk) begin
    bit ss;
    int o, p, wp;
    m_c++;
    wp = int'(write_pointer);
    ss = h3 && !h2;
    h3 = h2; h2 = h1; h1 = play_n;
    if (reset_clk) begin
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
      m_pc = 0; m_level = 512; m_pwm = 1'b0; m_sample = 512; m_rp = 0;
      m_active = 1'b0; m_done = 1'b0;
    end else begin
      m_pwm = (m_pc < m_level);
      if (m_pc == 1023) m_level = m_sample;
      m_pc = (m_pc + 1) % 1024;
      m_done = 1'b0;
      if (m_active) begin
        o = m_c - m_t0;
        if (!record_n || (LOOP && ss)) begin
          m_active = 1'b0; m_rp = 0; m_sample = 512;
        end else if (o % SI == 0) begin
          p = o / SI;
          if (LOOP) begin
            m_rp = p % wp;
            if (m_rp == 0) m_done = 1'b1;
          end else if (p < wp) begin
            m_rp = p;
          end else begin
            m_active = 1'b0; m_rp = 0; m_sample = 512; m_done = 1'b1;
          end
        end else if (o % SI == RL + 1) begin
          m_sample = (int'(mem[((o / SI) % wp)]) + 512) % 1024;
        end
      end else if (ss && record_n && wp != 0) begin
        m_active = 1'b1; m_t0 = m_c; m_rp = 0;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock, then every output against the model.
  task automatic tick();
    logic [27:0] got, exp;
    @(posedge clk);
    #1;
    got = {read_pointer, sample_out, pwm_out, playing, done};
    exp = {15'(m_rp), 10'(m_sample), m_pwm, m_active, m_done};
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL cycle%0d: observed rp=%0d smp=%0d pwm=%b ply=%b done=%b expected rp=%0d smp=%0d pwm=%b ply=%b done=%b",
             m_c, got[27:13], got[12:3], got[2], got[1], got[0],
             exp[27:13], exp[12:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_playing(input string tag);
    int n = 0;
    while (!playing && n < 20) begin tick(); n++; end
    chk(tag, int'(playing), 1);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin tick(); n++; end
  endtask

  task automatic abort_play();
    record_n = 1'b0;
    tick();
    record_n = 1'b1;
    tick();
  endtask

  initial begin
    int exp1 [4];
    int n, dn, starts, highs;
    bit prev, do_abort;
    exp1 = '{512, 1023, 0, 511};

    reset_clk = 1'b1; play_n = 1'b1; record_n = 1'b1; write_pointer = 15'd0;
    for (int i = 0; i < 8; i++) mem[i] = 10'(i * 37);
    ticks(3);
    chk("rst_rp", int'(read_pointer), 0);
    chk("rst_sample", int'(sample_out), 512);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    reset_clk = 1'b0;
    ticks(5);

    // Four-sample clip covering both extremes and the midpoint.
    write_pointer = 15'd4;
    mem[0] = 10'h000; mem[1] = 10'h1FF; mem[2] = 10'h200; mem[3] = 10'h3FF;
    play_n = 1'b0;
    wait_playing("t1_start");
    ticks(10);
    play_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t1_sample", int'(sample_out), exp1[k]);
      chk("t1_rp", int'(read_pointer), k);
      if (k < 3) ticks(SI);
    end
    wait_done(2 * SI, n);
    chk("t1_done_time", n, SI - 10);
    if (!LOOP) begin
      chk("t1_end_rp", int'(read_pointer), 0);
      chk("t1_end_sample", int'(sample_out), 512);
      chk("t1_end_playing", int'(playing), 0);
    end
    tick();
    chk("t1_done_width", int'(done), 0);
    if (LOOP) abort_play();
    ticks(5);

    // Reset in the middle of HOLD.
    write_pointer = 15'd2;
    mem[0] = 10'h1FF;
    play_n = 1'b0;
    wait_playing("t2_start");
    ticks(SI / 2);
    play_n = 1'b1;
    chk("t2_pre_sample", int'(sample_out), 1023);
    reset_clk = 1'b1;
    tick();
    reset_clk = 1'b0;
    chk("t2_playing", int'(playing), 0);
    chk("t2_sample", int'(sample_out), 512);
    chk("t2_rp", int'(read_pointer), 0);
    chk("t2_pwm", int'(pwm_out), 0);
    ticks(5);

    // Abort during the second sample, then a press while record_n is low.
    write_pointer = 15'd4;
    for (int i = 0; i < 4; i++) mem[i] = 10'($urandom);
    play_n = 1'b0;
    wait_playing("t3_start");
    ticks(SI + SI / 2);
    play_n = 1'b1;
    chk("t3_rp_before", int'(read_pointer), 1);
    record_n = 1'b0;
    tick();
    chk("t3_abort_playing", int'(playing), 0);
    chk("t3_abort_rp", int'(read_pointer), 0);
    chk("t3_abort_sample", int'(sample_out), 512);
    dn = int'(done);
    for (int i = 0; i < 2 * SI; i++) begin tick(); dn += int'(done); end
    chk("t3_no_done", dn, 0);
    play_n = 1'b0;
    ticks(20);
    chk("t3_blocked", int'(playing), 0);
    play_n = 1'b1;
    record_n = 1'b1;
    ticks(5);

    // Empty clip, then a long press that must start exactly one playback.
    write_pointer = 15'd0;
    play_n = 1'b0;
    ticks(20);
    chk("t4_empty", int'(playing), 0);
    play_n = 1'b1;
    ticks(5);
    write_pointer = 15'd2;
    play_n = 1'b0;
    starts = 0;
    prev = playing;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (playing && !prev) starts++;
      prev = playing;
    end
    chk("t4_one_start", starts, 1);
    play_n = 1'b1;
    if (LOOP) abort_play();
    ticks(5);

    // Steady level 768 gives 768 high clocks per 1024.
    write_pointer = 15'd1;
    mem[0] = 10'h100;
    play_n = 1'b0;
    wait_playing("t5_start");
    ticks(1100);
    play_n = 1'b1;
    chk("t5_sample", int'(sample_out), 768);
    highs = 0;
    for (int i = 0; i < 1024; i++) begin tick(); highs += int'(pwm_out); end
    chk("t5_duty", highs, 768);
    if (LOOP) abort_play();
    else begin
      n = 0;
      while (playing && n < SI) begin tick(); n++; end
      chk("t5_end", int'(playing), 0);
    end
    ticks(5);

    // Random clips with an optional abort at a random point.
    for (int r = 0; r < 2; r++) begin
      write_pointer = 15'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) mem[i] = 10'($urandom);
      do_abort = 1'($urandom);
      play_n = 1'b0;
      wait_playing("rnd_start");
      ticks(5);
      play_n = 1'b1;
      if (do_abort || LOOP) begin
        ticks($urandom_range(1, int'(write_pointer) * SI - 10));
        abort_play();
      end else begin
        n = 0;
        while (playing && n < 4 * SI) begin tick(); n++; end
      end
      chk("rnd_idle", int'(playing), 0);
      ticks(5);
    end

`ifdef SOUND_LOOP_EN
    // Continuous loop over two samples, stopped by a second press.
    write_pointer = 15'd2;
    mem[0] = 10'h010; mem[1] = 10'h020;
    play_n = 1'b0;
    wait_playing("t6_start");
    ticks(10);
    play_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_rp", int'(read_pointer), k % 2);
      if (k < 3) ticks(SI);
    end
    wait_done(2 * SI, n);
    chk("t6_first_done", n, SI - 10);
    tick();
    wait_done(3 * SI, n);
    chk("t6_done_period", n + 1, 2 * SI);
    ticks(10);
    play_n = 1'b0;
    dn = 0;
    for (int i = 0; i < 6; i++) begin tick(); dn += int'(done); end
    play_n = 1'b1;
    chk("t6_stop", int'(playing), 0);
    chk("t6_stop_no_done", dn, 0);
    ticks(5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
